if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-register PC/adder fetch with a decoupled front end. It keeps the fetch PC, issues word requests to a variable-latency instruction memory (one outstanding), and buffers returned {PC, instruction} pairs in a QUEUE_DEPTH-entry FIFO drained by the ID stage with a valid/ready handshake. It sits between instruction memory and the IF/ID boundary and adds PC-relative branch redirection with flush and a freeze input for hazard stalls.

---
 rtl/if_fetch_queue.sv | 131 +++++++++++++
 tb/tb_if_fetch_queue.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end: keeps the fetch PC, issues one
// outstanding word request to a variable-latency instruction memory and
// buffers returned {PC, instruction} pairs in a small FIFO that the ID stage
// drains with a valid/ready handshake. A taken branch redirects the PC,
// flushes the FIFO and discards any response that is still in flight.
module if_fetch_queue #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   QUEUE_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter int                   PC_STEP     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           brTaken,
    input  logic [WORD_SIZE-1:0]           brOffset,
    input  logic [WORD_SIZE-1:0]           brBasePC,
    input  logic                           freeze,
    output logic                           memReq,
    output logic [WORD_SIZE-1:0]           memAddr,
    input  logic                           memRespValid,
    input  logic [WORD_SIZE-1:0]           memRespData,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [WORD_SIZE-1:0]           PC,
    output logic [WORD_SIZE-1:0]           instruction,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // IDLE: free to issue, WAIT: response owed to the queue,
    // DROP: response owed but stale after a redirect, to be discarded.
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetchState_t;

    fetchState_t            state_reg;
    logic [WORD_SIZE-1:0]   fetchPC_reg;
    logic [WORD_SIZE-1:0]   reqPC_reg;
    logic [PTR_W-1:0]       rdPtr_reg;
    logic [PTR_W-1:0]       wrPtr_reg;
    logic [CNT_W-1:0]       count_reg;

    logic [QUEUE_DEPTH-1:0][WORD_SIZE-1:0] pcArr;
    logic [QUEUE_DEPTH-1:0][WORD_SIZE-1:0] instrArr;

    logic                   doPush;
    logic                   doPop;
    logic [WORD_SIZE-1:0]   brTarget;

    // Offset is a word offset; the shift drops its top two bits and the add wraps.
    assign brTarget = brBasePC + (brOffset << 2);

    // A redirect cycle never issues, and a full queue holds off new requests.
    assign memReq  = !rst && (state_reg == IDLE) && !brTaken && !freeze
                     && (count_reg < CNT_W'(QUEUE_DEPTH));
    assign memAddr = fetchPC_reg;

    // A flush wins over both the push of an arriving word and a pop.
    assign doPush = !rst && !brTaken && (state_reg == WAIT) && memRespValid;
    assign doPop  = !rst && !brTaken && (count_reg != '0) && outReady;

    assign outValid    = !rst && (count_reg != '0);
    assign PC          = rst ? '0 : pcArr[rdPtr_reg];
    assign instruction = rst ? '0 : instrArr[rdPtr_reg];
    assign count       = rst ? '0 : count_reg;

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : gEntry
            logic [WORD_SIZE-1:0] pcEntry_reg;
            logic [WORD_SIZE-1:0] instrEntry_reg;

            // Queue slot: cleared on reset, written when the push lands here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pcEntry_reg    <= '0;
                    instrEntry_reg <= '0;
                end else if (doPush && (wrPtr_reg == PTR_W'(gi))) begin
                    pcEntry_reg    <= reqPC_reg;
                    instrEntry_reg <= memRespData;
                end
            end

            assign pcArr[gi]    = pcEntry_reg;
            assign instrArr[gi] = instrEntry_reg;
        end
    endgenerate

    // Fetch control FSM plus queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            fetchPC_reg <= RESET_PC;
            reqPC_reg   <= '0;
            rdPtr_reg   <= '0;
            wrPtr_reg   <= '0;
            count_reg   <= '0;
        end else if (brTaken) begin
            fetchPC_reg <= brTarget;
            rdPtr_reg   <= '0;
            wrPtr_reg   <= '0;
            count_reg   <= '0;
            // An in-flight request becomes stale unless its word arrives right now.
            if (state_reg == WAIT) begin
                state_reg <= memRespValid ? IDLE : DROP;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (memReq) begin
                        reqPC_reg   <= fetchPC_reg;
                        fetchPC_reg <= fetchPC_reg + WORD_SIZE'(PC_STEP);
                        state_reg   <= WAIT;
                    end
                end
                WAIT: if (memRespValid) state_reg <= IDLE;
                DROP: if (memRespValid) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (doPush) wrPtr_reg <= wrPtr_reg + 1'b1;
            if (doPop)  rdPtr_reg <= rdPtr_reg + 1'b1;

            case ({doPush, doPop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a reset/free-run vector table, hand-written
// redirect/freeze/reset corner sequences, and a randomized run, all also
// checked every cycle against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int          W    = 32;
    localparam int          D    = 4;
    localparam int          STEP = 4;
    localparam logic [31:0] RPC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        brTaken = 1'b0;
    logic [31:0] brOffset = '0;
    logic [31:0] brBasePC = '0;
    logic        freeze = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic [2:0]  count;

    if_fetch_queue #(
        .WORD_SIZE(W), .QUEUE_DEPTH(D), .RESET_PC(RPC), .PC_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .brTaken(brTaken), .brOffset(brOffset),
        .brBasePC(brBasePC), .freeze(freeze), .memReq(memReq),
        .memAddr(memAddr), .memRespValid(memRespValid),
        .memRespData(memRespData), .outValid(outValid), .outReady(outReady),
        .PC(PC), .instruction(instruction), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of fetched pairs and the request in flight.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;
    entry_t      mq[$];
    logic [31:0] mFetch = RPC;
    bit          mPend = 0;
    bit          mStale = 0;
    logic [31:0] mPendPC = '0;

    // Memory responder state.
    int          respCnt = 0;
    logic [31:0] respAddr = '0;
    int          latMode = 1;

    // Outputs sampled at the falling edge of the last cycle.
    logic        sReq, sValid;
    logic [31:0] sAddr, sPC, sIns;
    logic [2:0]  sCount;

    function automatic logic [31:0] memWord(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(bit expReq);
        bit resp;
        bit pop;
        if (rst) begin
            mq.delete();
            mFetch = RPC;
            mPend  = 0;
            mStale = 0;
        end else begin
            resp = mPend && memRespValid;
            pop  = (mq.size() > 0) && outReady;
            if (brTaken) begin
                mq.delete();
                mFetch = brBasePC + brOffset * 4;
                if (mPend && !mStale) begin
                    if (resp) mPend = 0;
                    else      mStale = 1;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (resp) begin
                    if (!mStale) mq.push_back(entry_t'{pc: mPendPC, ins: memRespData});
                    mPend  = 0;
                    mStale = 0;
                end
                if (expReq) begin
                    mPend   = 1;
                    mStale  = 0;
                    mPendPC = mFetch;
                    mFetch  = mFetch + STEP;
                end
            end
        end
    endtask

    // One clock: sample and check at negedge, advance model and memory at posedge.
    task automatic cycle();
        bit expReq;
        @(negedge clk);
        sReq = memReq; sAddr = memAddr; sValid = outValid;
        sPC = PC; sIns = instruction; sCount = count;
        expReq = !rst && !mPend && !brTaken && !freeze && (mq.size() < D);
        check("model_memReq", sReq, expReq);
        check("model_memAddr", sAddr, mFetch);
        check("model_outValid", sValid, !rst && (mq.size() > 0));
        check("model_count", sCount, rst ? 0 : mq.size());
        if (rst) begin
            check("rst_PC", sPC, 0);
            check("rst_instr", sIns, 0);
        end else if (mq.size() > 0) begin
            check("model_PC", sPC, mq[0].pc);
            check("model_instr", sIns, mq[0].ins);
        end
        if (sValid && outReady)
            $display("POP t=%0t pc=%h instr=%h count=%0d", $time, sPC, sIns, sCount);
        @(posedge clk);
        modelStep(expReq);
        if (sReq) begin
            respCnt  = (latMode == 0) ? int'($urandom_range(1, 3)) : latMode;
            respAddr = sAddr;
        end
        #1;
        if (respCnt > 0) begin
            respCnt--;
            memRespValid = (respCnt == 0);
            memRespData  = memRespValid ? memWord(respAddr) : $urandom;
        end else begin
            memRespValid = 1'b0;
            memRespData  = $urandom;
        end
    endtask

    task automatic doReset();
        rst = 1'b1; brTaken = 1'b0; freeze = 1'b0;
        respCnt = 0; memRespValid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rstIn;
        bit          rdy;
        bit          eReq;
        logic [31:0] eAddr;
        bit          eValid;
        logic [31:0] ePC;
        logic [2:0]  eCnt;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit found;

        // Reset, then free-run with one-cycle memory and an always-ready ID stage.
        tbl[0]  = '{1, 1, 0, 32'd0,  0, 32'd0,  3'd0};
        tbl[1]  = '{1, 1, 0, 32'd0,  0, 32'd0,  3'd0};
        tbl[2]  = '{0, 1, 1, 32'd0,  0, 32'd0,  3'd0};
        tbl[3]  = '{0, 1, 0, 32'd4,  0, 32'd0,  3'd0};
        tbl[4]  = '{0, 1, 1, 32'd4,  1, 32'd0,  3'd1};
        tbl[5]  = '{0, 1, 0, 32'd8,  0, 32'd0,  3'd0};
        tbl[6]  = '{0, 1, 1, 32'd8,  1, 32'd4,  3'd1};
        tbl[7]  = '{0, 1, 0, 32'd12, 0, 32'd0,  3'd0};
        tbl[8]  = '{0, 1, 1, 32'd12, 1, 32'd8,  3'd1};
        tbl[9]  = '{0, 1, 0, 32'd16, 0, 32'd0,  3'd0};
        tbl[10] = '{0, 1, 1, 32'd16, 1, 32'd12, 3'd1};

        latMode = 1;
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rstIn;
            outReady = tbl[i].rdy;
            cycle();
            check("tbl_memReq", sReq, tbl[i].eReq);
            check("tbl_memAddr", sAddr, tbl[i].eAddr);
            check("tbl_outValid", sValid, tbl[i].eValid);
            check("tbl_count", sCount, tbl[i].eCnt);
            if (tbl[i].eValid) begin
                check("tbl_PC", sPC, tbl[i].ePC);
                check("tbl_instr", sIns, memWord(tbl[i].ePC));
            end
        end

        // Fill the queue with the ID stage stalled, then drain in order.
        doReset();
        latMode = 1; outReady = 1'b0;
        repeat (12) cycle();
        check("full_count", sCount, 4);
        check("full_noReq", sReq, 0);
        outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("drain_PC", sPC, 4 * k);
            if (k == 1) begin
                check("resume_memReq", sReq, 1);
                check("resume_memAddr", sAddr, 16);
            end
        end

        // Redirect while a request is outstanding: its response is dropped.
        doReset();
        latMode = 3; outReady = 1'b1;
        cycle();
        check("br_issue0", sReq, 1);
        brTaken = 1'b1; brBasePC = 32'h40; brOffset = 32'hFFFF_FFFE;
        cycle();
        brTaken = 1'b0;
        check("br_noReq", sReq, 0);
        cycle();
        check("br_flushed", sCount, 0);
        check("br_target", sAddr, 32'h38);
        check("br_dropWait", sReq, 0);
        cycle();
        check("br_dropResp", sReq, 0);
        cycle();
        check("br_newReq", sReq, 1);
        check("br_newAddr", sAddr, 32'h38);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            found = sValid;
        end
        check("br_headSeen", found, 1);
        check("br_headPC", sPC, 32'h38);
        check("br_headInstr", sIns, memWord(32'h38));

        // Redirect in the very cycle the response arrives.
        doReset();
        latMode = 3;
        cycle();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (memRespValid) found = 1;
            else cycle();
        end
        check("brResp_respSeen", found, 1);
        brTaken = 1'b1; brBasePC = 32'h100; brOffset = 32'd4;
        cycle();
        brTaken = 1'b0;
        cycle();
        check("brResp_count", sCount, 0);
        check("brResp_memReq", sReq, 1);
        check("brResp_memAddr", sAddr, 32'h110);

        // Freeze for five cycles with a request pending.
        doReset();
        latMode = 3; outReady = 1'b0;
        cycle();
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("freeze_noReq", sReq, 0);
        end
        freeze = 1'b0;
        cycle();
        check("freeze_pushed", sCount, 1);
        check("freeze_resume", sReq, 1);
        check("freeze_addr", sAddr, 4);

        // Reset in the middle of a pending request, then a late response.
        doReset();
        latMode = 3; outReady = 1'b1;
        cycle();
        rst = 1'b1; freeze = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        check("rstWait_count", sCount, 0);
        check("rstWait_valid", sValid, 0);
        check("rstWait_addr", sAddr, RPC);
        freeze = 1'b0;
        cycle();
        check("rstWait_req", sReq, 1);
        check("rstWait_reqAddr", sAddr, RPC);

        // Randomized traffic against the model.
        doReset();
        latMode = 0;
        for (int n = 0; n < 1500; n++) begin
            outReady = ($urandom_range(0, 3) != 0);
            freeze   = ($urandom_range(0, 7) == 0);
            brBasePC = $urandom;
            brOffset = $urandom;
            brTaken  = ($urandom_range(0, 19) == 0) && !(memRespValid && mStale);
            cycle();
        end
        brTaken = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
